// File: rtl/updn_cnt_pkg.sv
// Shared types and next-count helper for updown_counter.
// Optional build macro: UPDN_CNT_SAT_EN selects saturate-at-bound instead of wrap.
package updn_cnt_pkg;

  // Widest counter supported; the helper works at this width and callers truncate.
  localparam int unsigned UPDN_W = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Result of one step: the next count and whether the step hit a bound
  // (wrapped, or stayed pinned in saturating mode).
  typedef struct packed {
    logic [UPDN_W-1:0] count;
    logic              flag;
  } updn_step_t;

  function automatic updn_step_t updn_next(
    input logic [UPDN_W-1:0] count,
    input dir_e              dir,
    input logic [UPDN_W-1:0] max
  );
    updn_step_t r;
    r.count = count;
    r.flag  = 1'b0;
    if (dir == DIR_UP) begin
      // >= rather than == keeps the count inside 0..max even from an odd state.
      if (count >= max) begin
        r.flag  = 1'b1;
`ifdef UPDN_CNT_SAT_EN
        r.count = max;
`else
        r.count = '0;
`endif
      end else begin
        r.count = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        r.flag  = 1'b1;
`ifdef UPDN_CNT_SAT_EN
        r.count = '0;
`else
        r.count = max;
`endif
      end else begin
        r.count = count - 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_counter.sv
// Parametrised up/down modulo counter with enable, clamped parallel load and
// registered terminal-count flag.
// Optional build macro: UPDN_CNT_SAT_EN (saturate at 0/MAX, tc held while pinned).
module updown_counter
  import updn_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX     = (1 << WIDTH) - 1,
  parameter int unsigned RST_VAL = MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0]  MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0]  RST_V   = WIDTH'(RST_VAL);
  localparam logic [UPDN_W-1:0] MAX_EXT = UPDN_W'(MAX);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  updn_step_t       w_step;
  logic [WIDTH-1:0] w_next_count;
  logic             w_bound;
  logic [WIDTH-1:0] w_load_clamped;

  // Step value for this cycle and clamped load value.
  always_comb begin
    w_step         = updn_next(UPDN_W'(r_count), dir_e'(up), MAX_EXT);
    w_next_count   = WIDTH'(w_step.count);
    w_bound        = w_step.flag;
    w_load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
  end

  // Count/tc register: rst > load > en > hold; tc only set by a bound step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RST_V;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
    end else if (en) begin
      r_count <= w_next_count;
      r_tc    <= w_bound;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down modulo counter; successor to the fixed 4-bit down counter. Adds configurable width and modulus, direction select, count enable, parallel load and a registered terminal-count pulse. Used as the general timing/sequencing counter in testbenches and control blocks.

## Interface
- WIDTH, 4, counter width in bits (legal 2..16)
- MAX, 2**WIDTH-1, top value of the count range 0..MAX (legal 1..2**WIDTH-1)
- RST_VAL, MAX, count value loaded by reset (must be <= MAX)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- en  input  1  count enable; 1 = step one position this cycle
- up  input  1  direction; 1 = count up, 0 = count down
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value for parallel load
- count  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered

## Operation
- Priority per rising edge: rst > load > en > hold.
- rst=1: count <= RST_VAL, tc <= 0.
- load=1: count <= load_val if load_val <= MAX, else MAX (clamped); tc <= 0; en and up ignored.
- en=1, up=1: count < MAX -> count+1, tc <= 0; count == MAX -> wrap to 0, tc <= 1.
- en=1, up=0: count > 0 -> count-1, tc <= 0; count == 0 -> wrap to MAX, tc <= 1.
- en=0 (no load, no rst): count holds, tc <= 0.
- Direction may change on any cycle; next step uses the up sampled on that edge.
- Arithmetic is WIDTH bits; count never leaves 0..MAX, including MAX < 2**WIDTH-1 (e.g. MAX=9 -> decade counter 0..9).
- No state machine beyond the count register and tc flop.

## Timing
- Reset values: count = RST_VAL, tc = 0.
- Latency: one cycle from en/load/rst sampled to new count visible.
- tc is high exactly one cycle, coinciding with the cycle count shows the wrapped value (0 going up, MAX going down).
- Continuous en across a wrap: tc high one cycle per wrap, low otherwise.
- load and en together: load wins, no step, no tc.
- rst asserted mid-count: next edge count = RST_VAL, tc = 0, regardless of load/en.
- No combinational path from inputs to outputs.

## Configuration
- Macro: UPDN_CNT_SAT_EN.
- Defined: saturating mode. At count == MAX going up (or 0 going down) with en=1, count holds and tc <= 1; tc stays high each cycle the counter is pinned at the bound with en=1 in that direction. Leaving the bound (reverse direction, load, rst) clears tc next edge.
- Not defined: wrap-around behaviour as in Operation; tc is a single-cycle pulse per wrap.

## Structure
- Package updn_cnt_pkg: enum dir_e {DIR_DOWN = 0, DIR_UP = 1} used for up, plus function updn_next(count, dir, max) returning next count and wrap/bound flag.
- Single module, no sub-module; next-state logic via the package function.

## Test plan
- WIDTH=4, MAX=15: rst=1 one edge -> count=15, tc=0; en=1, up=0, 16 edges -> 14..0 then 15, tc high only on the edge count becomes 15.
- MAX=9, up=1, en=1 from load_val=7 -> 8, 9, 0 (tc=1 that cycle), 1.
- load=1, en=1, load_val=12 with MAX=9 -> count=9, tc=0.
- en=1 toggling up every 3 cycles from 5 -> 6,7,8,7,6,5; en=0 two cycles -> count holds, tc=0.
- rst=1 while en=1, load=1 at count=3 -> count=RST_VAL, tc=0 next edge.
- UPDN_CNT_SAT_EN defined, MAX=15, count=14, up=1, en=1 four edges -> 15,15,15,15; tc = 0,1,1,1; then up=0 -> 14, tc=0.
